// File: rtl/riscv_mc_control.sv
// Multicycle control FSM for the RV32I-subset CPU: sequences fetch/decode/execute/memory/writeback,
// drives datapath mux selects and strobes, and counts retired instructions.
module riscv_mc_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        old_pc_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_ctl,
  output logic        pc_source,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  logic pc_write_c, old_pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c, illegal_c;
  logic [3:0] exec_ctl;
  logic       exec_ok;

  always_comb begin
    exec_ok  = 1'b1;
    exec_ctl = ALU_ADD;
    case (funct3)
      3'b000:  exec_ctl = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  exec_ctl = ALU_SLT;
      3'b110:  exec_ctl = ALU_OR;
      3'b111:  exec_ctl = ALU_AND;
      default: exec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_write_c     = 1'b0;
    old_pc_write_c = 1'b0;
    ir_write_c     = 1'b0;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;
    reg_write_c    = 1'b0;
    illegal_c      = 1'b0;
    i_or_d         = 1'b0;
    mem_to_reg     = 1'b0;
    alu_src_a      = 2'b00;
    alu_src_b      = 2'b00;
    alu_ctl        = ALU_ADD;
    pc_source      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b01;
        if (mem_ready) begin
          ir_write_c     = 1'b1;
          pc_write_c     = 1'b1;
          old_pc_write_c = 1'b1;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target OldPC + imm is parked in ALUOut for BRANCH to use.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE, OP_ITYPE: state_d = S_EXEC;
          OP_BRANCH: state_d = S_BRANCH;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 2'b10;
        alu_src_b = (opcode == OP_RTYPE) ? 2'b00 : 2'b10;
        if (exec_ok) begin
          alu_ctl = exec_ctl;
          state_d = S_ALUWB;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctl   = ALU_SUB;
        pc_source = 1'b1;
        if (funct3 == 3'b000) begin
          pc_write_c = alu_zero;
          state_d    = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_TRAP: illegal_c = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  // An instruction retires on its final transition back to FETCH.
  always_comb begin
    instret_d = instret_q;
    if (state_d == S_FETCH &&
        (state_q == S_MEMWB || state_q == S_MEMWR || state_q == S_ALUWB || state_q == S_BRANCH))
      instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are masked during reset so an aborted instruction cannot write anything.
  assign pc_write     = pc_write_c & rst_n;
  assign old_pc_write = old_pc_write_c & rst_n;
  assign ir_write     = ir_write_c & rst_n;
  assign mem_read     = mem_read_c & rst_n;
  assign mem_write    = mem_write_c & rst_n;
  assign reg_write    = reg_write_c & rst_n;
  assign illegal      = illegal_c & rst_n;
  assign state        = state_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Randomized self-checking bench for riscv_mc_control: a per-instruction cycle-sequence model
// derived from the instruction-class rules predicts every cycle's outputs.
module tb_riscv_mc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        alu_zero;
  logic        mem_ready;
  logic        pc_write, old_pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_write, pc_source, illegal;
  logic [1:0]  alu_src_a, alu_src_b;
  logic [3:0]  alu_ctl, state;
  logic [31:0] instret;

  riscv_mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .old_pc_write(old_pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctl(alu_ctl), .pc_source(pc_source), .illegal(illegal), .state(state),
    .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011, BRANCH = 7'b1100011, BAD = 7'b1111111;

  typedef struct {
    logic [3:0]  st;
    logic        rdy;
    logic        zero;
    logic [17:0] ctl;
    logic [31:0] ret;
  } cyc_t;

  cyc_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned model_ret = 0;
  logic [17:0] obs_ctl;

  assign obs_ctl = {pc_write, old_pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, alu_ctl, pc_source, illegal};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] sig(input logic pcw, opw, irw, iod, mr, mw, m2r, rw,
                                      input logic [1:0] sa, sb, input logic [3:0] ac,
                                      input logic ps, il);
    return {pcw, opw, irw, iod, mr, mw, m2r, rw, sa, sb, ac, ps, il};
  endfunction

  // ALU op for arithmetic instructions: {legal, code}.
  function automatic logic [4:0] alu_code(input logic [2:0] f3, input logic f7, input logic rtype);
    case (f3)
      3'b000:  return {1'b1, (rtype && f7) ? 4'd6 : 4'd2};
      3'b010:  return {1'b1, 4'd7};
      3'b110:  return {1'b1, 4'd1};
      3'b111:  return {1'b1, 4'd0};
      default: return {1'b0, 4'd2};
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic zero,
                      input logic [17:0] ctl);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.zero = zero; c.ctl = ctl; c.ret = model_ret;
    q.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic build_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int fw, input int mw, input logic zero, output bit trapped);
    logic [4:0] ac;
    trapped = 1'b0;
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, rb(), sig(0,0,0,0,1,0,0,0, 2'd0, 2'd1, 4'd2, 0, 0));
    push(4'd0, 1'b1, rb(), sig(1,1,1,0,1,0,0,0, 2'd0, 2'd1, 4'd2, 0, 0));
    push(4'd1, rb(), rb(), sig(0,0,0,0,0,0,0,0, 2'd1, 2'd2, 4'd2, 0, 0));
    case (op)
      LOAD, STORE: begin
        push(4'd2, rb(), rb(), sig(0,0,0,0,0,0,0,0, 2'd2, 2'd2, 4'd2, 0, 0));
        if (op == LOAD) begin
          for (int i = 0; i <= mw; i++)
            push(4'd3, i == mw, rb(), sig(0,0,0,1,1,0,0,0, 2'd0, 2'd0, 4'd2, 0, 0));
          push(4'd4, rb(), rb(), sig(0,0,0,0,0,0,1,1, 2'd0, 2'd0, 4'd2, 0, 0));
        end else begin
          for (int i = 0; i <= mw; i++)
            push(4'd5, i == mw, rb(), sig(0,0,0,1,0,1,0,0, 2'd0, 2'd0, 4'd2, 0, 0));
        end
        model_ret++;
      end
      RTYPE, ITYPE: begin
        ac = alu_code(f3, f7, op == RTYPE);
        push(4'd6, rb(), rb(), sig(0,0,0,0,0,0,0,0, 2'd2, (op == RTYPE) ? 2'd0 : 2'd2, ac[3:0], 0, 0));
        if (ac[4]) begin
          push(4'd7, rb(), rb(), sig(0,0,0,0,0,0,0,1, 2'd0, 2'd0, 4'd2, 0, 0));
          model_ret++;
        end else trapped = 1'b1;
      end
      BRANCH: begin
        push(4'd8, rb(), zero, sig((f3 == 3'b000) && zero,0,0,0,0,0,0,0, 2'd2, 2'd0, 4'd6, 1, 0));
        if (f3 == 3'b000) model_ret++;
        else trapped = 1'b1;
      end
      default: trapped = 1'b1;
    endcase
    if (trapped)
      for (int i = 0; i < 3; i++) push(4'd9, rb(), rb(), sig(0,0,0,0,0,0,0,0, 2'd0, 2'd0, 4'd2, 0, 1));
  endtask

  // Entered at posedge+1; returns at the next posedge+1.
  task automatic applyStimulus(input cyc_t c);
    mem_ready = c.rdy;
    alu_zero  = c.zero;
    #2;
    checkOutput($sformatf("state@%0d", c.st), 32'(state), 32'(c.st));
    checkOutput($sformatf("ctl@st%0d", c.st), 32'(obs_ctl), 32'(c.ctl));
    checkOutput($sformatf("instret@st%0d", c.st), instret, c.ret);
    @(posedge clk);
    #1;
  endtask

  task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input int fw, input int mw, input logic zero, output bit trapped);
    opcode = op; funct3 = f3; funct7b5 = f7;
    build_instr(op, f3, f7, fw, mw, zero, trapped);
    while (q.size() > 0) applyStimulus(q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_state"}, 32'(state), 32'd0);
    checkOutput({tag, "_ctl"}, 32'(obs_ctl), 32'(sig(0,0,0,0,0,0,0,0, 2'd0, 2'd1, 4'd2, 0, 0)));
    checkOutput({tag, "_instret"}, instret, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    alu_zero = 1'b1;
    #2;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    check_reset_outputs("rst1");
    rst_n = 1'b1;
    model_ret = 0;
    q.delete();
  endtask

  bit          trapped;
  logic [6:0]  op;
  logic [2:0]  f3;
  int          r;

  initial begin
    rst_n = 1'b0; opcode = RTYPE; funct3 = 3'b000; funct7b5 = 1'b0;
    alu_zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    exec_instr(RTYPE, 3'b000, 1'b0, 0, 0, 1'b0, trapped);
    exec_instr(RTYPE, 3'b000, 1'b1, 0, 0, 1'b0, trapped);
    exec_instr(ITYPE, 3'b010, 1'b1, 0, 0, 1'b0, trapped);
    exec_instr(ITYPE, 3'b110, 1'b0, 1, 0, 1'b0, trapped);
    exec_instr(ITYPE, 3'b111, 1'b0, 0, 0, 1'b0, trapped);
    exec_instr(ITYPE, 3'b000, 1'b1, 0, 0, 1'b0, trapped);
    exec_instr(LOAD, 3'b010, 1'b0, 0, 3, 1'b0, trapped);
    exec_instr(STORE, 3'b010, 1'b0, 2, 1, 1'b0, trapped);
    exec_instr(BRANCH, 3'b000, 1'b0, 0, 0, 1'b1, trapped);
    exec_instr(BRANCH, 3'b000, 1'b0, 0, 0, 1'b0, trapped);
    exec_instr(BAD, 3'b000, 1'b0, 0, 0, 1'b0, trapped);
    do_reset();
    exec_instr(RTYPE, 3'b011, 1'b0, 0, 0, 1'b0, trapped);
    do_reset();
    exec_instr(BRANCH, 3'b001, 1'b0, 0, 0, 1'b1, trapped);
    do_reset();

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r < 4) op = LOAD;
      else if (r < 8) op = STORE;
      else if (r < 12) op = RTYPE;
      else if (r < 16) op = ITYPE;
      else if (r < 19) op = BRANCH;
      else op = 7'b1101111;
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (op == BRANCH) f3 = 3'b000;
      else begin
        case ($urandom_range(0, 3))
          0: f3 = 3'b000;
          1: f3 = 3'b010;
          2: f3 = 3'b110;
          default: f3 = 3'b111;
        endcase
      end
      exec_instr(op, f3, rb(), $urandom_range(0, 2), $urandom_range(0, 2), rb(), trapped);
      if (trapped) do_reset();
    end

    do_reset();
    exec_instr(RTYPE, 3'b000, 1'b0, 0, 0, 1'b0, trapped);
    opcode = STORE; funct3 = 3'b010;
    build_instr(STORE, 3'b010, 1'b0, 0, 3, 1'b0, trapped);
    while (q.size() > 0 && q[0].st != 4'd5) applyStimulus(q.pop_front());
    applyStimulus(q.pop_front());
    mem_ready = 1'b0;
    #1;
    checkOutput("pre_abort_mem_write", 32'(mem_write), 32'd1);
    checkOutput("pre_abort_instret", instret, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_mem_write", 32'(mem_write), 32'd0);
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_instret", instret, 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_hold_mem_write", 32'(mem_write), 32'd0);
    checkOutput("abort_hold_instret", instret, 32'd0);
    rst_n = 1'b1;
    model_ret = 0;
    q.delete();
    exec_instr(ITYPE, 3'b111, 1'b0, 0, 0, 1'b0, trapped);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
